pat_fetch: RTL and testbench

- Initiator for the shared pattern memory interface (EN/RW/add/inout data).
- On `start`, reads a contiguous run of deterministic test patterns from memory and streams them to the LBIST pattern consumer over a valid/ready handshake.
- A 2-entry buffer hides the memory's one-cycle registered read latency and sustains one pattern per cycle.

---
 rtl/pat_fetch.sv | 156 +++++++++++++++
 tb/tb_pat_fetch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pat_fetch.sv
// pat_fetch: reads a contiguous run of patterns from the shared memory and streams them to the LBIST consumer.
// Compile with PAT_FETCH_SIG_WB_EN defined to add the signature write-back (sig_in/sig_valid, WB state).
module pat_fetch #(
    parameter int word_size    = 8,
    parameter int address_bits = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [address_bits-1:0] base_add,
    input  logic [address_bits:0]   count,
    output logic                    mem_EN,
    output logic                    mem_RW,
    output logic [address_bits-1:0] mem_add,
    inout  wire  [word_size-1:0]    mem_data,
    output logic [word_size-1:0]    pat_out,
    output logic                    pat_valid,
    input  logic                    pat_ready,
    output logic                    busy,
    output logic                    done,
`ifdef PAT_FETCH_SIG_WB_EN
    input  logic [word_size-1:0]    sig_in,
    input  logic                    sig_valid,
`endif
    output logic [2:0]              fsm_state
);

    // Handshake: a pattern moves on a rising edge where pat_valid && pat_ready; once pat_valid is
    // raised, pat_valid and pat_out hold their value until that transfer happens.

`ifdef PAT_FETCH_SIG_WB_EN
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DRAIN = 3'd2, DONE = 3'd3, WB = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DRAIN = 3'd2, DONE = 3'd3} state_t;
`endif

    state_t                  state;
    logic [address_bits-1:0] base_r;
    logic [address_bits:0]   cnt_r;
    logic [address_bits:0]   issued;
    logic [address_bits:0]   received;
    logic                    pending;
    logic [word_size-1:0]    fifo [2];
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              occ;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    wb_fire;
    logic [2:0]              in_flight;

    assign pop       = pat_valid && pat_ready;
    assign push      = pending;
    assign in_flight = {1'b0, occ} + {2'b00, pending};

    // A slot is reserved for every outstanding read, so the buffer can never be pushed while full.
    assign issue = (state == FETCH) && (issued < cnt_r) && (in_flight < (3'd2 + {2'b00, pop}));

`ifdef PAT_FETCH_SIG_WB_EN
    assign wb_fire  = (state == WB) && sig_valid;
    assign mem_data = (mem_EN && mem_RW) ? sig_in : {word_size{1'bz}};
`else
    assign wb_fire  = 1'b0;
    assign mem_data = {word_size{1'bz}};
`endif

    assign mem_EN    = issue || wb_fire;
    assign mem_RW    = wb_fire;
    assign mem_add   = wb_fire ? (base_r + cnt_r[address_bits-1:0])
                               : (base_r + issued[address_bits-1:0]);
    assign pat_valid = (occ != 2'd0);
    assign pat_out   = fifo[rd_ptr];
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_r   <= '0;
            cnt_r    <= '0;
            issued   <= '0;
            received <= '0;
            pending  <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= issue;
            if (issue) begin
                issued <= issued + 1'b1;
            end
            // The memory's registered read word is on the bus exactly one cycle after the issue.
            if (push) begin
                fifo[wr_ptr] <= mem_data;
                wr_ptr       <= ~wr_ptr;
                received     <= received + 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base_r   <= base_add;
                        cnt_r    <= count;
                        issued   <= '0;
                        received <= '0;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue && ((issued + 1'b1) == cnt_r)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((received == cnt_r) && (occ == 2'd0)) begin
`ifdef PAT_FETCH_SIG_WB_EN
                        state <= WB;
`else
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef PAT_FETCH_SIG_WB_EN
                WB: begin
                    if (sig_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pat_fetch.sv
// tb_pat_fetch: table-driven runs of pat_fetch against a behavioural registered-read memory, with
// scoreboards for streamed patterns, read addresses and (PAT_FETCH_SIG_WB_EN) the signature write.
`timescale 1ns/1ps
module tb_pat_fetch;
    localparam int WS = 8;
    localparam int AB = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [AB-1:0] base_add  = '0;
    logic [AB:0]   count     = '0;
    logic          pat_ready = 1'b0;
    logic          mem_EN;
    logic          mem_RW;
    logic [AB-1:0] mem_add;
    wire  [WS-1:0] mem_data;
    logic [WS-1:0] pat_out;
    logic          pat_valid;
    logic          busy;
    logic          done;
    logic [2:0]    fsm_state;
`ifdef PAT_FETCH_SIG_WB_EN
    logic [WS-1:0] sig_in    = '0;
    logic          sig_valid = 1'b0;
`endif

    always #5 clk = ~clk;

    pat_fetch #(.word_size(WS), .address_bits(AB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_add  (base_add),
        .count     (count),
        .mem_EN    (mem_EN),
        .mem_RW    (mem_RW),
        .mem_add   (mem_add),
        .mem_data  (mem_data),
        .pat_out   (pat_out),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .busy      (busy),
        .done      (done),
`ifdef PAT_FETCH_SIG_WB_EN
        .sig_in    (sig_in),
        .sig_valid (sig_valid),
`endif
        .fsm_state (fsm_state)
    );

    // ---------------- memory model ----------------
    logic [WS-1:0] flash  [256];
    logic [WS-1:0] golden [256];
    logic [WS-1:0] mem_q = '0;

    assign mem_data = (mem_EN && mem_RW) ? {WS{1'bz}} : mem_q;

    always @(posedge clk) begin
        if (mem_EN && !mem_RW) mem_q <= flash[mem_add];
        if (mem_EN && mem_RW)  flash[mem_add] <= mem_data;
    end

    // ---------------- scoreboard ----------------
    logic [WS-1:0]    exp_q[$];
    logic [AB-1:0]    exp_add_q[$];
    logic [AB+WS-1:0] exp_wr_q[$];
    int               n_vec = 0;
    int               n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    int               in_flight = 0;
    bit               prev_stall = 1'b0;
    logic [WS-1:0]    prev_out = '0;
    bit               m_xfer, m_rd, m_wr;
    logic [AB+WS-1:0] m_w;

    // Reads issued and not yet transferred = buffer occupancy + pending read.
    always @(negedge clk) begin
        if (rst) begin
            in_flight  = 0;
            prev_stall = 1'b0;
        end else begin
            m_xfer = pat_valid && pat_ready;
            m_rd   = mem_EN && !mem_RW;
            m_wr   = mem_EN && mem_RW;
            if (prev_stall) begin
                check("stall_valid_hold", pat_valid, 1);
                check("stall_data_hold", pat_out, prev_out);
            end
            if (m_rd) begin
                if (exp_add_q.size() == 0) check("extra_read", exp_add_q.size(), 1);
                else check("read_add", mem_add, exp_add_q.pop_front());
                check("issue_rule", (in_flight - int'(m_xfer)) < 2, 1);
            end
            if (m_wr) begin
                if (exp_wr_q.size() == 0) check("extra_write", exp_wr_q.size(), 1);
                else begin
                    m_w = exp_wr_q.pop_front();
                    check("write_add", mem_add, m_w[AB+WS-1:WS]);
                    check("write_data", mem_data, m_w[WS-1:0]);
                end
            end else begin
                check("bus_not_driven", mem_data, mem_q);
            end
            if (m_xfer) begin
                if (exp_q.size() == 0) check("extra_pattern", exp_q.size(), 1);
                else check("pattern", pat_out, exp_q.pop_front());
            end
            in_flight = in_flight + int'(m_rd) - int'(m_xfer);
            if (m_rd) check("buffer_overflow", in_flight <= 2, 1);
            prev_stall = pat_valid && !pat_ready;
            prev_out   = pat_out;
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run(input logic [AB-1:0] b, input logic [AB:0] n, input int mode,
                       input bit poke, input logic [WS-1:0] sig);
        int            k;
        int            lat;
        int            valid_cycles;
        bit            got_done;
        bit            busy_drop;
        logic [AB-1:0] a;
        k = 0; lat = -1; valid_cycles = 0; got_done = 1'b0; busy_drop = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AB'(i);
            exp_add_q.push_back(a);
            exp_q.push_back(golden[a]);
        end
`ifdef PAT_FETCH_SIG_WB_EN
        if (n != '0) begin
            a = b + n[AB-1:0];
            exp_wr_q.push_back({a, sig});
            golden[a] = sig;
        end
        sig_in    = sig;
        sig_valid = 1'b1;
`endif
        @(posedge clk); #1;
        base_add = b; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // k counts rising edges after the one that sampled start.
        while (!got_done && k < 3000) begin
            if (pat_valid) begin
                valid_cycles++;
                if (lat < 0) lat = k;
            end
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (!busy) busy_drop = 1'b1;
                case (mode)
                    0:       pat_ready = 1'b1;
                    1:       pat_ready = (k % 3 == 0);
                    default: pat_ready = 1'($urandom_range(0, 1));
                endcase
                if (poke && k == 1) begin
                    start = 1'b1; base_add = 8'h80; count = 9'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        check("done_seen", got_done, 1);
        check("busy_low_with_done", busy, 0);
        if (n == '0) begin
            check("empty_done_latency", k, 0);
            check("empty_no_valid", valid_cycles, 0);
        end else begin
            check("first_valid_latency", lat, 2);
            check("busy_held_during_run", busy_drop, 0);
        end
        if (mode == 0) check("one_per_cycle", valid_cycles, int'(n));
        @(posedge clk); #1;
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
        check("patterns_all_seen", exp_q.size(), 0);
        check("reads_all_issued", exp_add_q.size(), 0);
        check("writes_all_seen", exp_wr_q.size(), 0);
        pat_ready = 1'b0;
`ifdef PAT_FETCH_SIG_WB_EN
        sig_valid = 1'b0;
`endif
    endtask

    task automatic reset_mid_run();
        for (int i = 0; i < 8; i++) exp_add_q.push_back(8'h10 + AB'(i));
        pat_ready = 1'b0;
        @(posedge clk); #1;
        base_add = 8'h10; count = 9'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_valid", pat_valid, 1);
        check("pre_reset_head", pat_out, golden[8'h10]);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #2;
        check("arst_mem_EN", mem_EN, 0);
        check("arst_mem_RW", mem_RW, 0);
        check("arst_mem_add", mem_add, 0);
        check("arst_pat_valid", pat_valid, 0);
        check("arst_pat_out", pat_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_bus", mem_data, mem_q);
        exp_q.delete();
        exp_add_q.delete();
        exp_wr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [AB-1:0] base;
        logic [AB:0]   cnt;
        int            mode;
        bit            poke;
    } vec_t;
    vec_t vecs [8];

    initial begin
        for (int i = 0; i < 256; i++) begin
            flash[i]  = 8'(i);
            golden[i] = 8'(i);
        end
        vecs[0] = '{8'h10, 9'd4,   0, 1'b0};
        vecs[1] = '{8'h10, 9'd4,   1, 1'b0};
        vecs[2] = '{8'hFE, 9'd4,   0, 1'b0};
        vecs[3] = '{8'h00, 9'd0,   0, 1'b0};
        vecs[4] = '{8'h30, 9'd16,  2, 1'b1};
        vecs[5] = '{8'hF0, 9'd20,  1, 1'b0};
        vecs[6] = '{8'h05, 9'd1,   0, 1'b0};
        vecs[7] = '{8'h80, 9'd256, 2, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_EN", mem_EN, 0);
        check("reset_mem_RW", mem_RW, 0);
        check("reset_mem_add", mem_add, 0);
        check("reset_pat_valid", pat_valid, 0);
        check("reset_pat_out", pat_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        reset_mid_run();

        for (int v = 0; v < 8; v++) begin
            run(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].poke, 8'($urandom_range(0, 255)));
        end

`ifdef PAT_FETCH_SIG_WB_EN
        run(8'h20, 9'd2, 0, 1'b0, 8'hA5);
        run(8'h22, 9'd1, 0, 1'b0, 8'h5A);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
